// File: rtl/fir_axis_out_buf.sv
// fir_axis_out_buf: FIFO between the FIR stream output and the sink, regenerating tlast from the programmed length
module fir_axis_out_buf #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pLEN_WIDTH  = 32
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst,
    input  logic                     cfg_start,
    input  logic [pLEN_WIDTH-1:0]    cfg_data_length,
    input  logic                     s_tvalid,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic                     m_tvalid,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     done,
    output logic                     tlast_err,
    output logic [$clog2(pDEPTH):0]  level
);
    localparam int AW = $clog2(pDEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
    logic [1:0] state_q, state_d;
    logic [pLEN_WIDTH-1:0] len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, len_m1;
    logic err_q, err_d, push, pop, arm, in_last, out_last;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    always_comb begin
        len_m1    = len_q - pLEN_WIDTH'(1);
        in_last   = in_cnt_q == len_m1;
        out_last  = out_cnt_q == len_m1;
        arm       = cfg_start && (state_q == S_IDLE || state_q == S_DONE);
        s_tready  = state_q == S_RUN && level_q != (AW+1)'(pDEPTH);
        m_tvalid  = |level_q;
        m_tdata   = m_tvalid ? mem_q[rd_ptr_q] : '0;
        m_tlast   = m_tvalid && out_last;
        busy      = state_q == S_RUN || state_q == S_DRAIN;
        done      = state_q == S_DONE;
        tlast_err = err_q;
        level     = level_q;
        push      = s_tvalid && s_tready;
        pop       = m_tvalid && m_tready;
        level_d   = level_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        in_cnt_d  = in_cnt_q + pLEN_WIDTH'(push);
        out_cnt_d = out_cnt_q + pLEN_WIDTH'(pop);
        err_d     = err_q | (push && (s_tlast != in_last));
        len_d     = len_q;
        state_d   = (state_q == S_RUN && push && in_last) ? S_DRAIN :
                    (state_q == S_DRAIN && pop && out_last) ? S_DONE : state_q;
        // Start is only honoured when idle or done; the FIFO is empty then, so counters can be cleared safely
        if (arm) begin
            len_d     = cfg_data_length;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            err_d     = 1'b0;
            state_d   = cfg_data_length == '0 ? S_DONE : S_RUN;
        end
    end
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end
    always_ff @(posedge axis_clk) begin
        if (push) mem_q[wr_ptr_q] <= s_tdata;
    end
endmodule

// File: tb/tb_fir_axis_out_buf.sv
// tb_fir_axis_out_buf: vector table, directed corner sequences and random transfers against a queue model
module tb_fir_axis_out_buf;
    localparam int DEPTH = 8;
    localparam int unsigned NONE = 32'hFFFF_FFFF;
    logic axis_clk = 1'b0, axis_rst = 1'b1, cfg_start = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
    logic [31:0] cfg_data_length = '0, s_tdata = '0, m_tdata;
    logic s_tready, m_tvalid, m_tlast, busy, done, tlast_err;
    logic [3:0] level;
    int checks = 0, errors = 0;
    logic [31:0] q [$];
    int unsigned mlen = 0, npush = 0, npop = 0, last_cnt = 0;
    int phase = 0;
    bit merr = 0, acc = 0;
    logic [31:0] last_data = '0;
    logic p_sready, p_valid, p_last;

    fir_axis_out_buf #(.pDATA_WIDTH(32), .pDEPTH(DEPTH), .pLEN_WIDTH(32)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .cfg_start(cfg_start), .cfg_data_length(cfg_data_length),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy), .done(done), .tlast_err(tlast_err), .level(level)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, a, e);
        end
    endtask

    // Phases: 0 idle, 1 accepting, 2 draining, 3 done
    function automatic void predict();
        p_valid  = q.size() != 0;
        p_sready = phase == 1 && q.size() < DEPTH;
        p_last   = p_valid && npop == mlen - 1;
    endfunction

    task automatic drive(input logic st, input logic [31:0] ln, input logic v, input logic [31:0] d,
                         input logic l, input logic r, input logic rs);
        cfg_start = st; cfg_data_length = ln; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r; axis_rst = rs;
        #1;
    endtask

    task automatic mcheck();
        predict();
        chk("s_tready", s_tready, p_sready);
        chk("m_tvalid", m_tvalid, p_valid);
        if (p_valid) chk("m_tdata", m_tdata, q[0]);
        chk("m_tlast", m_tlast, p_last);
        chk("busy", busy, phase == 1 || phase == 2);
        chk("done", done, phase == 3);
        chk("tlast_err", tlast_err, merr);
        chk("level", level, q.size());
        if (m_tvalid && m_tready && m_tlast) begin
            last_cnt++;
            last_data = m_tdata;
        end
    endtask

    task automatic adv();
        bit push, pop, st, l, rs;
        int ph;
        logic [31:0] d, ln;
        predict();
        push = s_tvalid && p_sready; pop = p_valid && m_tready; ph = phase;
        st = cfg_start; ln = cfg_data_length; d = s_tdata; l = s_tlast; rs = axis_rst;
        acc = push;
        @(posedge axis_clk); #1;
        if (rs) begin
            q.delete(); phase = 0; mlen = 0; npush = 0; npop = 0; merr = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                npop++;
                if (ph == 2 && npop == mlen) phase = 3;
            end
            if (push) begin
                q.push_back(d);
                if (l != (npush == mlen - 1)) merr = 1;
                npush++;
                if (ph == 1 && npush == mlen) phase = 2;
            end
            if (st && (ph == 0 || ph == 3)) begin
                mlen = ln; npush = 0; npop = 0; merr = 0;
                phase = ln == 0 ? 3 : 1;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic [31:0] ln, input logic v, input logic [31:0] d,
                       input logic l, input logic r, input logic rs);
        drive(st, ln, v, d, l, r, rs);
        mcheck();
        adv();
    endtask

    task automatic xfer(input int unsigned ln, input int pv, input int pr, input int unsigned bad);
        int unsigned idx = 0;
        int n = 0;
        logic [31:0] d = $urandom;
        cyc(1, ln, 0, 0, 0, 1, 0);
        while (phase != 3 && n < 400) begin
            cyc($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 99) < pv, d,
                (idx == ln - 1) ^ (idx == bad), $urandom_range(0, 99) < pr, 0);
            if (acc) begin
                idx++;
                d = $urandom;
            end
            n++;
        end
        chk("xfer_done", done, 1);
        chk("xfer_beats", idx, ln);
    endtask

    typedef struct {
        logic st; logic [31:0] ln; logic v; logic [31:0] d; logic l; logic r;
        logic e_rdy; logic e_val; logic [31:0] e_dat; logic e_last; logic e_done; logic [3:0] e_lvl;
    } vec_t;
    vec_t tv [7];

    initial begin
        int idx, n;
        tv[0] = '{1, 4, 0,  0, 0, 1,  0, 0,  0, 0, 0, 0};
        tv[1] = '{0, 0, 1, 10, 0, 1,  1, 0,  0, 0, 0, 0};
        tv[2] = '{0, 0, 1, 20, 0, 1,  1, 1, 10, 0, 0, 1};
        tv[3] = '{0, 0, 1, 30, 0, 1,  1, 1, 20, 0, 0, 1};
        tv[4] = '{0, 0, 1, 40, 1, 1,  1, 1, 30, 0, 0, 1};
        tv[5] = '{0, 0, 0,  0, 0, 1,  0, 1, 40, 1, 0, 1};
        tv[6] = '{0, 0, 0,  0, 0, 1,  0, 0,  0, 0, 1, 0};
        repeat (2) @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_valid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_busy_done", {busy, done, tlast_err, s_tready, m_tlast}, 0);

        for (int i = 0; i < 7; i++) begin
            drive(tv[i].st, tv[i].ln, tv[i].v, tv[i].d, tv[i].l, tv[i].r, 0);
            mcheck();
            chk($sformatf("tv%0d_rdy", i), s_tready, tv[i].e_rdy);
            chk($sformatf("tv%0d_val", i), m_tvalid, tv[i].e_val);
            if (tv[i].e_val) chk($sformatf("tv%0d_dat", i), m_tdata, tv[i].e_dat);
            chk($sformatf("tv%0d_last", i), m_tlast, tv[i].e_last);
            chk($sformatf("tv%0d_done", i), done, tv[i].e_done);
            chk($sformatf("tv%0d_lvl", i), level, tv[i].e_lvl);
            chk($sformatf("tv%0d_err", i), tlast_err, 0);
            adv();
        end

        // Back-pressure until full, then a pop-only cycle, refill and drain
        cyc(1, 12, 0, 0, 0, 0, 0);
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 100 + idx, idx == 11, 0, 0);
            if (acc) idx++;
        end
        chk("full_level", level, 8);
        chk("full_sready", s_tready, 0);
        chk("full_pushed", idx, 8);
        cyc(0, 0, 1, 100 + idx, idx == 11, 1, 0);
        if (acc) idx++;
        chk("pop_level", level, 7);
        chk("pop_sready", s_tready, 1);
        chk("pop_nopush", idx, 8);
        cyc(0, 0, 1, 100 + idx, idx == 11, 0, 0);
        if (acc) idx++;
        chk("refill_level", level, 8);
        n = 0;
        last_cnt = 0;
        while (phase != 3 && n < 100) begin
            cyc(0, 0, idx < 12, 100 + idx, idx == 11, 1, 0);
            if (acc) idx++;
            n++;
        end
        chk("wrap_done", done, 1);
        chk("wrap_beats", idx, 12);
        chk("wrap_lasts", last_cnt, 1);
        chk("wrap_last_data", last_data, 111);

        // Early tlast on beat 2 of 3
        cyc(1, 3, 0, 0, 0, 1, 0);
        idx = 0;
        last_cnt = 0;
        n = 0;
        while (phase != 3 && n < 50) begin
            cyc(0, 0, idx < 3, 300 + idx, idx == 1, 1, 0);
            if (acc) idx++;
            if (idx == 2 && acc) chk("early_err", tlast_err, 1);
            n++;
        end
        chk("early_done", done, 1);
        chk("early_err_held", tlast_err, 1);
        chk("early_lasts", last_cnt, 1);
        chk("early_last_data", last_data, 302);

        // Zero length: immediate done, no handshake
        cyc(1, 0, 1, 7, 0, 1, 0);
        chk("zero_err_clr", tlast_err, 0);
        chk("zero_done", done, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 7, 0, 1, 0);
            chk("zero_sready", s_tready, 0);
            chk("zero_valid", m_tvalid, 0);
        end

        // Reset in the middle of a transfer
        cyc(1, 20, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 500 + i, 0, 0, 0);
        chk("mid_level", level, 5);
        chk("mid_busy", busy, 1);
        cyc(0, 0, 1, 505, 0, 0, 1);
        chk("abort_level", level, 0);
        chk("abort_valid", m_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sready", s_tready, 0);
        xfer(2, 100, 100, NONE);

        for (int t = 0; t < 15; t++) begin
            int unsigned ln;
            ln = $urandom_range(0, 20);
            xfer(ln, 70, 60, $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : NONE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_axis_out_buf.md
Name: fir_axis_out_buf

Overview:
- Output-side buffer that sits directly downstream of the FIR core's AXI-Stream master port (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Absorbs FIR results in a small FIFO so that sink back-pressure does not stall the tap pipeline.
- Counts beats against the programmed data length and regenerates tlast on the final output beat.
- Flags a sticky error when the FIR's own tlast disagrees with the programmed length.

Parameters:
- pDATA_WIDTH, 32: stream data width.
- pDEPTH, 8: FIFO depth in entries; must be a power of 2, at least 2.
- pLEN_WIDTH, 32: width of the data-length register and beat counters.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst  in  1  reset, synchronous, active-high.
- cfg_start  in  1  one-cycle pulse that begins a transfer.
- cfg_data_length  in  pLEN_WIDTH  number of beats in the transfer; sampled on cfg_start.
- s_tvalid  in  1  from FIR sm_tvalid.
- s_tdata  in  pDATA_WIDTH  from FIR sm_tdata.
- s_tlast  in  1  from FIR sm_tlast.
- s_tready  out  1  to FIR sm_tready.
- m_tvalid  out  1  downstream valid.
- m_tdata  out  pDATA_WIDTH  downstream data.
- m_tlast  out  1  downstream last; generated by this block, not forwarded.
- m_tready  in  1  downstream ready.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- tlast_err  out  1  sticky tlast mismatch flag; cleared by cfg_start.
- level  out  $clog2(pDEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (axis_rst=1 at a clock edge):
  - All outputs go to 0; state=IDLE.
  - FIFO pointers, level, in_cnt, out_cnt and len are cleared; stored FIFO contents are discarded.
  - Reset mid-transfer aborts the transfer with no drain.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: s_tready=0. On cfg_start: latch len=cfg_data_length, clear in_cnt/out_cnt/tlast_err. Go to DONE if len==0, else RUN.
  - RUN: s_tready = !full. A push occurs when s_tvalid && s_tready. On a push with in_cnt==len-1, go to DRAIN. Otherwise increment in_cnt on each push.
  - DRAIN: s_tready=0. Stay until the pop with out_cnt==len-1, then go to DONE.
  - DONE: done=1, held. cfg_start re-arms exactly as in IDLE (DONE -> RUN, or -> DONE if len==0).
  - cfg_start in RUN or DRAIN is ignored: len and counters are unchanged.
- FIFO (circular buffer):
  - pDEPTH entries; read/write pointers of $clog2(pDEPTH) bits that wrap modulo pDEPTH.
  - full = (level==pDEPTH); empty = (level==0).
  - m_tvalid = !empty. m_tdata = entry at the read pointer (first-word fall-through from the registered array).
  - Latency: a beat pushed at edge N appears on m_tvalid/m_tdata after edge N (visible cycle N+1). Minimum push-to-output latency is 1 cycle.
  - A pop occurs when m_tvalid && m_tready; out_cnt increments on each pop.
  - Simultaneous push and pop: both take effect and level is unchanged. When full, a pop frees space but s_tready stays 0 in that cycle, because s_tready depends only on level and has no path from m_tready.
  - Push is never accepted when full; pop is never performed when empty.
  - Once asserted, m_tvalid/m_tdata are held stable until the pop (AXI-Stream rule). The FIFO guarantees this.
- m_tlast = m_tvalid && (out_cnt==len-1). Exactly one m_tlast per transfer.
- tlast_err:
  - Set on a push where s_tlast != (in_cnt==len-1), i.e. early or missing last.
  - Stays set until the next accepted cfg_start. Data flow is unaffected.
- Beats presented while s_tready=0 are not consumed; the FIR holds them per AXI-Stream rules.
- Counter width is pLEN_WIDTH and the length is unsigned. len==0 means no beats: done is asserted the cycle after start.

Test Plan:
- Reset, then cfg_start with len=4; push 10,20,30,40 with s_tlast on 40; m_tready=1 throughout -> out 10,20,30,40, each 1 cycle after push; m_tlast only on 40; done=1; tlast_err=0.
- len=12, m_tready=0 while pushing continuously -> level reaches 8, s_tready drops to 0 after the 8th push; raising m_tready drains in order; all 12 beats delivered, no loss or duplicate; pointers wrap.
- Full FIFO with s_tvalid=1 and m_tready=1 in the same cycle -> exactly one pop; no push that cycle; push on the next cycle; level 8→7→8.
- len=3 with s_tlast on beat 2 -> tlast_err=1 after beat 2; m_tlast still on beat 3. Next cfg_start clears tlast_err.
- cfg_start with len=0 -> done=1 next cycle; s_tready never asserts; no m_tvalid.
- axis_rst asserted in RUN with level=5 -> next cycle: state IDLE, level=0, m_tvalid=0, busy=0; a new cfg_start with len=2 runs cleanly.
